// File: rtl/jt900h_memseq.sv
// rtl/jt900h_memseq.sv - splits byte/word/long CPU accesses into 16-bit bus pieces
// Handles odd alignment, 24-bit address wrap, read assembly and optional per-piece timeout.
module jt900h_memseq #(
    parameter int MAXWAIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        req,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        bus_cs,
    output logic        bus_we,
    output logic [23:0] bus_addr,
    output logic [1:0]  bus_dsn,
    output logic [15:0] bus_dout,
    input  logic [15:0] bus_din,
    input  logic        bus_ok
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [15:0] WAIT_LIM = (MAXWAIT > 0) ? 16'(MAXWAIT - 1) : 16'd0;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  idx_q, idx_d;
    logic        err_q, err_d;
    logic [15:0] wait_q, wait_d;

    logic [1:0]  npieces, off;
    logic        is_byte, last, timeout, active;
    logic [23:0] piece_addr;
    logic [1:0]  piece_dsn;
    logic [15:0] wb, piece_dout, din_eff, rins_lane;
    logic [7:0]  rb;
    logic [31:0] rins;

    // Piece table: off is both the address offset from A and the rdata/wdata byte position
    always_comb begin
        npieces = 2'd1;
        off     = 2'd0;
        is_byte = 1'b1;
        if (size_q == 2'd1) begin
            if (addr_q[0]) begin
                npieces = 2'd2;
                off     = idx_q;
            end else begin
                is_byte = 1'b0;
            end
        end else if (size_q != 2'd0) begin
            if (addr_q[0]) begin
                npieces = 2'd3;
                case (idx_q)
                    2'd0:    off = 2'd0;
                    2'd1:    begin off = 2'd1; is_byte = 1'b0; end
                    default: off = 2'd3;
                endcase
            end else begin
                npieces = 2'd2;
                is_byte = 1'b0;
                off     = {idx_q[0], 1'b0};
            end
        end
    end

    always_comb begin
        case (off)
            2'd0:    wb = wdata_q[15:0];
            2'd1:    wb = wdata_q[23:8];
            2'd2:    wb = wdata_q[31:16];
            default: wb = {8'h00, wdata_q[31:24]};
        endcase
    end

    assign active     = (state_q == ACCESS);
    assign last       = (idx_q == npieces - 2'd1);
    assign piece_addr = addr_q + {22'd0, off};
    assign piece_dsn  = is_byte ? (piece_addr[0] ? 2'b01 : 2'b10) : 2'b00;
    assign piece_dout = is_byte ? {wb[7:0], wb[7:0]} : wb;
    assign timeout    = (MAXWAIT > 0) && !bus_ok && (wait_q == WAIT_LIM);
    assign din_eff    = bus_ok ? bus_din : 16'h0000;
    assign rb         = piece_addr[0] ? din_eff[15:8] : din_eff[7:0];
    assign rins_lane  = is_byte ? {8'h00, rb} : din_eff;
    assign rins       = {16'h0000, rins_lane} << {off, 3'b000};

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        idx_d   = idx_q;
        err_d   = err_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: if (req) begin
                we_d    = req_we;
                size_d  = req_size;
                addr_d  = req_addr;
                wdata_d = req_wdata;
                rdata_d = 32'h0;
                idx_d   = 2'd0;
                err_d   = 1'b0;
                wait_d  = 16'd0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus_ok || timeout) begin
                    if (!we_q) rdata_d = rdata_q | rins;
                    err_d  = err_q | timeout;
                    wait_d = 16'd0;
                    if (last) state_d = DONE;
                    else      idx_d   = idx_q + 2'd1;
                end else if (MAXWAIT > 0) begin
                    wait_d = wait_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 24'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            idx_q   <= 2'd0;
            err_q   <= 1'b0;
            wait_q  <= 16'd0;
        end else if (cen) begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    // Bus outputs are gated by state so reset idles the bus without waiting for a clock
    assign busy     = active;
    assign done     = (state_q == DONE);
    assign err      = done && err_q;
    assign rdata    = rdata_q;
    assign bus_cs   = active;
    assign bus_we   = active && we_q;
    assign bus_addr = active ? piece_addr : 24'h0;
    assign bus_dsn  = active ? piece_dsn : 2'b11;
    assign bus_dout = active ? piece_dout : 16'h0;

endmodule

// File: doc/jt900h_memseq.md
JT900H_MEMSEQ -- requirements
Module: jt900h_memseq

Interface
REQ-001 SHALL have parameter MAXWAIT, default 0, meaning: max cen cycles of wait per bus piece; 0 = unlimited.
REQ-002 SHALL have port clk  input  1  system clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cen  input  1  clock enable; all state advances only on clk edges with cen=1.
REQ-005 SHALL have port req  input  1  start transaction; sampled only in IDLE.
REQ-006 SHALL have port req_we  input  1  1=write, 0=read.
REQ-007 SHALL have port req_size  input  2  0=byte, 1=word, 2=long, 3=reserved (treated as long).
REQ-008 SHALL have port req_addr  input  24  byte address from the index address unit.
REQ-009 SHALL have port req_wdata  input  32  write data, little-endian.
REQ-010 SHALL have port busy  output  1  high from accept until done.
REQ-011 SHALL have port done  output  1  one-cen-cycle completion pulse.
REQ-012 SHALL have port err  output  1  high with done if any piece timed out.
REQ-013 SHALL have port rdata  output  32  assembled read data.
REQ-014 SHALL have port bus_cs  output  1  bus cycle active.
REQ-015 SHALL have port bus_we  output  1  bus write.
REQ-016 SHALL have port bus_addr  output  24  piece address.
REQ-017 SHALL have port bus_dsn  output  2  active-low lane strobes; [0]=low lane (even byte, bits 7:0), [1]=high lane (odd byte, bits 15:8).
REQ-018 SHALL have port bus_dout  output  16  write data.
REQ-019 SHALL have port bus_din  input  16  read data.
REQ-020 SHALL have port bus_ok  input  1  piece acknowledge.

Function
REQ-021 SHALL implement states IDLE, ACCESS, DONE.
REQ-022 IDLE: req=1 on a cen cycle SHALL latch we/size/addr/wdata, compute piece list, go ACCESS; busy=1 and bus_cs=1 from the next cycle.
REQ-023 Piece lists SHALL be: byte -> 1 byte piece; word even -> 1 word piece (dsn=00); word odd -> byte@A (high lane), byte@A+1 (low lane); long even -> word@A, word@A+2; long odd -> byte@A, word@A+1, byte@A+3.
REQ-024 Byte piece dsn SHALL be 2'b10 for even address, 2'b01 for odd address.
REQ-025 Piece addresses SHALL be computed modulo 2^24 (0xFFFFFF+1 wraps to 0x000000).
REQ-026 ACCESS: bus_cs SHALL stay high; bus_ok=1 on a cen cycle SHALL complete the current piece; the next piece's addr/dsn/dout SHALL appear the following cycle with bus_cs still high.
REQ-027 Write lanes: byte pieces SHALL drive the byte on both lanes; word pieces SHALL drive {hi,lo} of the corresponding wdata bytes (odd long: piece1 = wdata[23:8]).
REQ-028 Read: each acknowledged piece SHALL store the addressed lane(s) of bus_din into its rdata byte position; unwritten rdata bytes SHALL be 0 (zero-extension).
REQ-029 Last piece acknowledged SHALL go DONE: bus_cs=0, busy=0, done=1 for exactly one cen cycle, then IDLE.
REQ-030 rdata SHALL be valid with done and held until the next accepted req.
REQ-031 req while busy SHALL be ignored; req in DONE SHALL be ignored (accepted only in IDLE).
REQ-032 With MAXWAIT>0, a per-piece counter SHALL count cen cycles without bus_ok; on reaching MAXWAIT the piece SHALL complete as if acknowledged (read lanes captured as 0) and a sticky error flag SHALL set, output as err with done; the flag clears on next accept.
REQ-033 Zero-wait latency: req accepted cycle N -> done at N+1+pieces.
REQ-034 cen=0 SHALL freeze all state and outputs.

Reset
REQ-035 rst SHALL force immediately: state IDLE, busy=0, done=0, err=0, bus_cs=0, bus_we=0, bus_dsn=2'b11, bus_addr=0, bus_dout=0, rdata=0, wait counter=0.
REQ-036 rst during ACCESS SHALL abort the transaction with no done pulse.

Verification
REQ-037 Word read A=0x001000, bus_ok always 1, din=0xBEEF -> cs cycles N+1 only, dsn=00, done N+2, rdata=0x0000BEEF.
REQ-038 Long write A=0x000101, wdata=0x44332211 -> pieces (0x000101,dsn=01,dout=0x1111),(0x000102,dsn=00,dout=0x3322),(0x000104,dsn=10,dout=0x4444), done N+4.
REQ-039 Word read A=0xFFFFFF, din=0xAA00 then 0x00BB -> addrs 0xFFFFFF then 0x000000, rdata=0x0000BBAA.
REQ-040 Byte read A=0x000200 with bus_ok low 3 cen cycles, MAXWAIT=0 -> cs held 4 cycles, done once, err=0; cen toggling mid-wait changes nothing.
REQ-041 MAXWAIT=2, bus_ok stuck low, word read -> piece ends after 2 cycles, done=1 with err=1, rdata=0.
REQ-042 rst asserted during second piece of long read -> bus_cs=0 same cycle, no done; subsequent req runs normally.
